grid_scanout_reader: RTL and testbench

- Read side of the 40x30 one-bit cell framebuffer in sram_module; the write side is the game logic that redraws the grid after each move.
- Prefetches one cell row into a double-buffered line buffer, using only cycles in which the writer has released the SRAM.
- Converts visible_x/visible_y into a registered pixel_state for the video path.
- Drop-in replacement for the current combinational-lookup pixel driver.

---
 rtl/grid_pkg.sv | 39 +++
 rtl/grid_line_buffer.sv | 78 +++++++
 rtl/grid_scanout_reader.sv | 151 +++++++++++++++
 tb/tb_grid_scanout_reader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared constants, types and address helper for the 40x30 one-bit cell grid.
// Used by both the scanout reader and the game-logic writer.
package grid_pkg;

  localparam int CELL_WIDTH  = 8;
  localparam int CELL_HEIGHT = 8;
  localparam int GRID_COLS   = 40;
  localparam int GRID_ROWS   = 30;
  localparam int RAM_LENGTH  = GRID_COLS * GRID_ROWS;
  localparam int ADDR_WIDTH  = 11;

  localparam int COORD_W   = 10;
  localparam int COL_SHIFT = $clog2(CELL_WIDTH);
  localparam int ROW_SHIFT = $clog2(CELL_HEIGHT);
  localparam int COL_W     = COORD_W - COL_SHIFT;
  localparam int ROW_W     = COORD_W - ROW_SHIFT;
  // Fetch column counter must also hold GRID_COLS as its "all issued" value.
  localparam int FCOL_W    = $clog2(GRID_COLS + 1);

  typedef logic [COL_W-1:0]      col_t;
  typedef logic [ROW_W-1:0]      row_t;
  typedef logic [FCOL_W-1:0]     fcol_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam col_t  NUM_COLS  = col_t'(GRID_COLS);
  localparam row_t  NUM_ROWS  = row_t'(GRID_ROWS);
  localparam row_t  LAST_ROW  = row_t'(GRID_ROWS - 1);
  localparam fcol_t FETCH_END = fcol_t'(GRID_COLS);
  localparam fcol_t LAST_COL  = fcol_t'(GRID_COLS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic addr_t cell_addr(input row_t row, input fcol_t col);
    return addr_t'(int'(row) * GRID_COLS + int'(col));
  endfunction

endpackage

// File: rtl/grid_line_buffer.sv
// Double-buffered cell row store: the fetcher fills the back row bit by bit,
// the pixel path reads the front row; a swap strobe promotes back to front.
module grid_line_buffer
  import grid_pkg::*;
(
  input  logic                 clk_74a,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  fcol_t                wr_col,
  input  logic                 wr_bit,
  input  logic                 commit,
  input  row_t                 commit_row,
  input  logic                 discard,
  input  logic                 swap,
  output logic [GRID_COLS-1:0] front_buf,
  output logic                 front_valid,
  output row_t                 front_row,
  output logic                 back_valid,
  output row_t                 back_row
);

  logic [GRID_COLS-1:0] front_buf_q, front_buf_d;
  logic [GRID_COLS-1:0] back_buf_q, back_buf_d;
  logic                 front_valid_q, front_valid_d;
  logic                 back_valid_q, back_valid_d;
  row_t                 front_row_q, front_row_d;
  row_t                 back_row_q, back_row_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    front_buf_d   = front_buf_q;
    back_buf_d    = back_buf_q;
    front_valid_d = front_valid_q;
    back_valid_d  = back_valid_q;
    front_row_d   = front_row_q;
    back_row_d    = back_row_q;

    if (wr_en) back_buf_d[wr_col] = wr_bit;
    if (commit) begin
      back_valid_d = 1'b1;
      back_row_d   = commit_row;
    end
    if (discard) back_valid_d = 1'b0;
    if (swap) begin
      front_buf_d   = back_buf_q;
      front_valid_d = 1'b1;
      front_row_d   = back_row_q;
      back_valid_d  = 1'b0;
    end
  end

  // NOTE: the row data is storage gated by the valid tags, so it carries no reset.
  always_ff @(posedge clk_74a) begin
    front_buf_q <= front_buf_d;
    back_buf_q  <= back_buf_d;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      front_valid_q <= 1'b0;
      back_valid_q  <= 1'b0;
      front_row_q   <= '0;
      back_row_q    <= '0;
    end else begin
      front_valid_q <= front_valid_d;
      back_valid_q  <= back_valid_d;
      front_row_q   <= front_row_d;
      back_row_q    <= back_row_d;
    end
  end

  assign front_buf   = front_buf_q;
  assign front_valid = front_valid_q;
  assign front_row   = front_row_q;
  assign back_valid  = back_valid_q;
  assign back_row    = back_row_q;

endmodule

// File: rtl/grid_scanout_reader.sv
// Read side of the cell framebuffer: prefetches rows into a line buffer in idle
// SRAM cycles and drives a registered pixel_state. Optional: GRID_SCANOUT_CELL_GAP_EN.
module grid_scanout_reader
  import grid_pkg::*;
(
  input  logic                  clk_74a,
  input  logic                  reset_n,
  input  logic [COORD_W-1:0]    visible_x,
  input  logic [COORD_W-1:0]    visible_y,
  input  logic                  sram_rd_avail,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic                  sram_data_out,
  output logic                  pixel_state,
  output logic                  underrun
);

  logic [1:0] state_q, state_d;
  row_t       target_row_q, target_row_d;
  fcol_t      fetch_col_q, fetch_col_d;
  fcol_t      req_col_q, req_col_d;
  logic       req_live_q, req_live_d;
  addr_t      sram_addr_q, sram_addr_d;
  logic       pixel_q, pixel_d;
  logic       underrun_q, underrun_d;

  logic [GRID_COLS-1:0] front_buf;
  logic front_valid, back_valid;
  row_t front_row, back_row;
  logic wr_en, commit, discard, swap;

  col_t col;
  row_t row;
  logic row_in_grid, front_hit, back_hit, underrun_evt, abort;

  assign col          = visible_x[COORD_W-1:COL_SHIFT];
  assign row          = visible_y[COORD_W-1:ROW_SHIFT];
  assign row_in_grid  = row < NUM_ROWS;
  assign front_hit    = front_valid && (front_row == row);
  assign back_hit     = back_valid && (back_row == row);
  assign swap         = row_in_grid && !front_hit && back_hit;
  assign underrun_evt = row_in_grid && !front_hit && !back_hit;
  // A fetch already aimed at the missing row is left to finish rather than restarted.
  assign abort        = underrun_evt && (target_row_q != row);

  always_comb begin
    state_d      = state_q;
    target_row_d = target_row_q;
    fetch_col_d  = fetch_col_q;
    req_col_d    = req_col_q;
    req_live_d   = 1'b0;
    sram_addr_d  = sram_addr_q;
    underrun_d   = underrun_q | underrun_evt;
    wr_en        = 1'b0;
    commit       = 1'b0;
    discard      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!back_valid) begin
          state_d     = ST_REQ;
          fetch_col_d = '0;
          sram_addr_d = cell_addr(target_row_q, '0);
        end
      end
      ST_REQ: begin
        if (req_live_q) begin
          wr_en = 1'b1;
          if (req_col_q == LAST_COL) begin
            commit  = 1'b1;
            state_d = ST_DONE;
          end
        end
        // The address on the bus is only consumed when the port was ours this cycle.
        if (sram_rd_avail && (fetch_col_q != FETCH_END)) begin
          req_live_d  = 1'b1;
          req_col_d   = fetch_col_q;
          fetch_col_d = fetch_col_q + 1'b1;
          if (fetch_col_q != LAST_COL)
            sram_addr_d = cell_addr(target_row_q, fetch_col_q + 1'b1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (swap) begin
      state_d      = ST_IDLE;
      target_row_d = (row == LAST_ROW) ? '0 : row + 1'b1;
    end else if (abort) begin
      state_d      = ST_IDLE;
      target_row_d = row;
      req_live_d   = 1'b0;
      wr_en        = 1'b0;
      commit       = 1'b0;
      discard      = 1'b1;
    end
  end

  always_comb begin
    pixel_d = row_in_grid && (col < NUM_COLS) && front_hit && front_buf[col[FCOL_W-1:0]];
`ifdef GRID_SCANOUT_CELL_GAP_EN
    if ((&visible_x[COL_SHIFT-1:0]) || (&visible_y[ROW_SHIFT-1:0])) pixel_d = 1'b0;
`else
`endif
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      target_row_q <= '0;
      fetch_col_q  <= '0;
      req_col_q    <= '0;
      req_live_q   <= 1'b0;
      sram_addr_q  <= '0;
      pixel_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
      state_q      <= state_d;
      target_row_q <= target_row_d;
      fetch_col_q  <= fetch_col_d;
      req_col_q    <= req_col_d;
      req_live_q   <= req_live_d;
      sram_addr_q  <= sram_addr_d;
      pixel_q      <= pixel_d;
      underrun_q   <= underrun_d;
    end
  end

  grid_line_buffer u_line_buffer (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_col      (req_col_q),
    .wr_bit      (sram_data_out),
    .commit      (commit),
    .commit_row  (target_row_q),
    .discard     (discard),
    .swap        (swap),
    .front_buf   (front_buf),
    .front_valid (front_valid),
    .front_row   (front_row),
    .back_valid  (back_valid),
    .back_row    (back_row)
  );

  assign sram_addr   = sram_addr_q;
  assign pixel_state = pixel_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_grid_scanout_reader.sv
// Randomised bench for grid_scanout_reader against a cell-grid pixel model.
// Also exercises GRID_SCANOUT_CELL_GAP_EN when built with that macro.
module tb_grid_scanout_reader;

  logic        clk_74a = 1'b0;
  logic        reset_n;
  logic [9:0]  visible_x, visible_y;
  logic        sram_rd_avail;
  logic [10:0] sram_addr;
  logic        sram_data_out;
  logic        pixel_state;
  logic        underrun;

  grid_scanout_reader dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .visible_x     (visible_x),
    .visible_y     (visible_y),
    .sram_rd_avail (sram_rd_avail),
    .sram_addr     (sram_addr),
    .sram_data_out (sram_data_out),
    .pixel_state   (pixel_state),
    .underrun      (underrun)
  );

  always #7 clk_74a = ~clk_74a;

  bit mem [1200];

  // SRAM: data one cycle after the address; garbage whenever the writer owned the port.
  always @(posedge clk_74a)
    sram_data_out <= (sram_rd_avail && sram_addr < 11'd1200) ? mem[int'(sram_addr)]
                                                             : 1'($urandom);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_pixel(input int x, input int y);
    int c, r;
    c = x / 8;
    r = y / 8;
    if (c >= 40 || r >= 30) return 1'b0;
`ifdef GRID_SCANOUT_CELL_GAP_EN
    if (x % 8 == 7 || y % 8 == 7) return 1'b0;
`endif
    return mem[r * 40 + c];
  endfunction

  bit pend_on  = 1'b0;
  bit pend_exp = 1'b0;
  int pend_x, pend_y;
  int last_row = -1;
  bit tog      = 1'b0;

  function automatic bit pick_avail(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       begin tog = ~tog; return tog; end
      2:       return 1'b0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // One clock: check the previous cycle's pixel, then present new inputs.
  // mode 0 = no check, 1 = model, 2 = must be dark.
  task automatic step(input int x, input int y, input bit avail, input int mode);
    int r;
    @(posedge clk_74a); #1;
    if (pend_on) check($sformatf("pix(%0d,%0d)", pend_x, pend_y), 32'(pixel_state), 32'(pend_exp));
    visible_x     = 10'(x);
    visible_y     = 10'(y);
    sram_rd_avail = avail;
    r        = y / 8;
    pend_on  = (mode != 0);
    // A row's first cycle is still looked up in the previous front row.
    pend_exp = (mode == 1) && (r == last_row) && model_pixel(x, y);
    pend_x   = x;
    pend_y   = y;
    last_row = r;
  endtask

  task automatic scan_line(input int y, input int avail_mode, input int mode);
    int x;
    repeat (4) step($urandom_range(320, 639), y, pick_avail(avail_mode), mode);
    x = 0;
    while (x < 320) begin
      step(x, y, pick_avail(avail_mode), mode);
      x += $urandom_range(1, 4);
    end
  endtask

  task automatic blank_cycles(input int n, input int avail_mode);
    repeat (n) step($urandom_range(0, 639), $urandom_range(240, 479), pick_avail(avail_mode), 1);
  endtask

  task automatic do_reset();
    @(posedge clk_74a); #1;
    reset_n       = 1'b0;
    visible_x     = 10'd0;
    visible_y     = 10'd300;
    sram_rd_avail = 1'b1;
    #1;
    check("rst_pixel", 32'(pixel_state), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(posedge clk_74a);
    @(negedge clk_74a);
    reset_n  = 1'b1;
    pend_on  = 1'b0;
    last_row = -1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1200; i++) mem[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset_n       = 1'b1;
    visible_x     = 10'd0;
    visible_y     = 10'd300;
    sram_rd_avail = 1'b1;

    // Row 0 = 0x5555555555: cell 0 lit, cell 1 dark.
    fill_random();
    do_reset();
    for (int c = 0; c < 40; c++) mem[c] = (c % 2 == 0);
    blank_cycles(45, 0);
    step(330, 0, 1'b1, 1);
    for (int x = 0; x < 16; x++) step(x, 0, 1'b1, 1);
    step(400, 0, 1'b1, 0);
    check("p1_underrun", 32'(underrun), 32'd0);

    // Reset in the middle of a fetch, then fetch with the port toggling every cycle.
    fill_random();
    do_reset();
    blank_cycles(20, 0);
    do_reset();
    blank_cycles(120, 1);
    scan_line(0, 0, 1);
    step(400, 0, 1'b1, 0);
    check("toggle_underrun", 32'(underrun), 32'd0);

    // Full frame with a random grid and random port availability, then row 0 of the next frame.
    fill_random();
    do_reset();
    blank_cycles(100, 3);
    for (int y = 0; y < 240; y++) scan_line(y, 3, 1);
    for (int y = 240; y < 250; y++) scan_line(y, 3, 1);
    for (int y = 0; y < 8; y++) scan_line(y, 3, 1);
    step(400, 300, 1'b1, 0);
    check("frame_underrun", 32'(underrun), 32'd0);

    // Writer holds the port across the start of row 5.
    fill_random();
    do_reset();
    blank_cycles(100, 0);
    for (int y = 0; y < 32; y++) scan_line(y, 0, 1);
    for (int y = 32; y < 40; y++) scan_line(y, 2, 1);
    check("pre_underrun", 32'(underrun), 32'd0);
    scan_line(40, 2, 2);
    check("underrun_set", 32'(underrun), 32'd1);
    scan_line(41, 0, 0);
    for (int y = 42; y < 56; y++) scan_line(y, 0, 1);
    step(400, 60, 1'b1, 0);
    check("underrun_sticky", 32'(underrun), 32'd1);

`ifdef GRID_SCANOUT_CELL_GAP_EN
    // All cells lit: only the gap pixels go dark.
    for (int i = 0; i < 1200; i++) mem[i] = 1'b1;
    do_reset();
    blank_cycles(60, 0);
    for (int y = 0; y < 24; y++) scan_line(y, 0, 1);
    step(400, 300, 1'b1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
